// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use hazard
// detection, bubble insertion and a saturating bubble counter.
module id_ex_operand_stage #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [DATA_W-1:0] id_rs1_data,
   input  logic [DATA_W-1:0] id_rs2_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_alu_src,
   input  logic [CTRL_W-1:0] id_alu_control,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd_addr,
   input  logic [DATA_W-1:0] exmem_alu_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd_addr,
   input  logic [DATA_W-1:0] memwb_wb_data,
   output logic              stall_if_id,
   output logic              ex_valid,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   output logic [CTRL_W-1:0] ex_alu_control,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic [CNT_W-1:0]  bubble_count
);

   logic              vld_p1;
   logic [REG_AW-1:0] rs1_addr_p1, rs2_addr_p1, rd_addr_p1;
   logic [DATA_W-1:0] rs1_data_p1, rs2_data_p1, imm_p1;
   logic              alu_src_p1, reg_write_p1, mem_read_p1, mem_write_p1;
   logic [CTRL_W-1:0] alu_control_p1;
   logic [CNT_W-1:0]  bubble_cnt_p1;
   logic              hz, insert_bubble, count_bubble;
   logic [DATA_W-1:0] rs1_fwd, rs2_fwd;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // x0 is never forwarded and always reads zero; EX/MEM beats MEM/WB
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [REG_AW-1:0] addr,
      input logic [DATA_W-1:0] rf_data,
      input logic              ex_we,
      input logic [REG_AW-1:0] ex_rd,
      input logic [DATA_W-1:0] ex_res,
      input logic              wb_we,
      input logic [REG_AW-1:0] wb_rd,
      input logic [DATA_W-1:0] wb_data
   );
      if (addr == '0)                     return '0;
      else if (ex_we && (ex_rd == addr))  return ex_res;
      else if (wb_we && (wb_rd == addr))  return wb_data;
      else                                return rf_data;
   endfunction

   assign hz = vld_p1 & mem_read_p1 & (rd_addr_p1 != '0) & id_valid
             & ((rd_addr_p1 == id_rs1_addr) | (rd_addr_p1 == id_rs2_addr));
   assign insert_bubble = flush | hz;
   assign count_bubble  = id_valid & insert_bubble;
   assign stall_if_id   = hz & ~flush;

   // ID -> EX register (p1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || insert_bubble) begin
         vld_p1         <= 1'b0;
         rs1_addr_p1    <= '0;
         rs2_addr_p1    <= '0;
         rd_addr_p1     <= '0;
         rs1_data_p1    <= '0;
         rs2_data_p1    <= '0;
         imm_p1         <= '0;
         alu_src_p1     <= 1'b0;
         alu_control_p1 <= '0;
         reg_write_p1   <= 1'b0;
         mem_read_p1    <= 1'b0;
         mem_write_p1   <= 1'b0;
      end else begin
         vld_p1         <= id_valid;
         rs1_addr_p1    <= id_rs1_addr;
         rs2_addr_p1    <= id_rs2_addr;
         rd_addr_p1     <= id_rd_addr;
         rs1_data_p1    <= id_rs1_data;
         rs2_data_p1    <= id_rs2_data;
         imm_p1         <= id_imm;
         alu_src_p1     <= id_alu_src;
         alu_control_p1 <= id_alu_control;
         reg_write_p1   <= id_reg_write;
         mem_read_p1    <= id_mem_read;
         mem_write_p1   <= id_mem_write;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            bubble_cnt_p1 <= '0;
      else if (count_bubble) bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
   end

   // EX stage operand selection
   assign rs1_fwd = fwd_sel(rs1_addr_p1, rs1_data_p1, exmem_reg_write, exmem_rd_addr,
                            exmem_alu_result, memwb_reg_write, memwb_rd_addr, memwb_wb_data);
   assign rs2_fwd = fwd_sel(rs2_addr_p1, rs2_data_p1, exmem_reg_write, exmem_rd_addr,
                            exmem_alu_result, memwb_reg_write, memwb_rd_addr, memwb_wb_data);

   assign ex_valid       = vld_p1;
   assign data1          = rs1_fwd;
   assign data2          = alu_src_p1 ? imm_p1 : rs2_fwd;
   assign ex_store_data  = rs2_fwd;
   assign ex_alu_control = alu_control_p1;
   assign ex_rd_addr     = rd_addr_p1;
   assign ex_reg_write   = reg_write_p1 & vld_p1;
   assign ex_mem_read    = mem_read_p1 & vld_p1;
   assign ex_mem_write   = mem_write_p1 & vld_p1;
   assign bubble_count   = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus hand-written
// reset, load-use and flush sequences.
module tb_id_ex_operand_stage;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1, rs2, rd;
      logic [7:0] rs1d, rs2d, imm;
      logic       src;
      logic [3:0] ctrl;
      logic       rw, mr, mw, flush;
      logic       xw;
      logic [4:0] xrd;
      logic [7:0] xres;
      logic       ww;
      logic [4:0] wrd;
      logic [7:0] wdat;
      logic       e_vld;
      logic [7:0] e_d1, e_d2, e_st;
      logic [3:0] e_ctrl;
      logic       e_rw, e_mw;
      logic [15:0] e_bc;
   } vec_t;

   logic        clk, rst_n;
   logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, flush;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, exmem_rd_addr, memwb_rd_addr;
   logic [7:0]  id_rs1_data, id_rs2_data, id_imm, exmem_alu_result, memwb_wb_data;
   logic [3:0]  id_alu_control;
   logic        exmem_reg_write, memwb_reg_write;
   logic        stall_if_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [7:0]  data1, data2, ex_store_data;
   logic [3:0]  ex_alu_control;
   logic [4:0]  ex_rd_addr;
   logic [15:0] bubble_count;

   int n_cmp = 0;
   int n_err = 0;
   vec_t vecs[10];
   vec_t cur;

   id_ex_operand_stage #(.DATA_W(8), .REG_AW(5), .CTRL_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
      .exmem_alu_result(exmem_alu_result), .memwb_reg_write(memwb_reg_write),
      .memwb_rd_addr(memwb_rd_addr), .memwb_wb_data(memwb_wb_data),
      .stall_if_id(stall_if_id), .ex_valid(ex_valid), .data1(data1), .data2(data2),
      .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .bubble_count(bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.valid;   id_rs1_addr = v.rs1;   id_rs2_addr = v.rs2;  id_rd_addr = v.rd;
      id_rs1_data = v.rs1d; id_rs2_data = v.rs2d;  id_imm = v.imm;       id_alu_src = v.src;
      id_alu_control = v.ctrl; id_reg_write = v.rw; id_mem_read = v.mr;  id_mem_write = v.mw;
      flush = v.flush;
      exmem_reg_write = v.xw; exmem_rd_addr = v.xrd; exmem_alu_result = v.xres;
      memwb_reg_write = v.ww; memwb_rd_addr = v.wrd; memwb_wb_data = v.wdat;
   endtask

   function automatic vec_t load_vec();
      vec_t v = '0;
      v.valid = 1'b1; v.rs1 = 5'd1; v.rd = 5'd5; v.imm = 8'h08;
      v.src = 1'b1; v.ctrl = 4'b0010; v.rw = 1'b1; v.mr = 1'b1;
      return v;
   endfunction

   function automatic vec_t dep_vec();
      vec_t v = '0;
      v.valid = 1'b1; v.rs1 = 5'd6; v.rs2 = 5'd5; v.rd = 5'd7; v.rs1d = 8'h01;
      v.ctrl = 4'b0010; v.rw = 1'b1;
      return v;
   endfunction

   initial begin
      // valid rs1 rs2 rd rs1d rs2d imm src ctrl rw mr mw flush | xw xrd xres | ww wrd wdat | e_vld e_d1 e_d2 e_st e_ctrl e_rw e_mw e_bc
      vecs[0] = '{1'b1,5'd1,5'd2,5'd3,8'h12,8'h34,8'h00,1'b0,4'b0010,1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b1,8'h12,8'h34,8'h34,4'b0010,1'b1,1'b0,16'd0};
      vecs[1] = '{1'b1,5'd4,5'd6,5'd10,8'hA0,8'h0B,8'hF0,1'b1,4'b0110,1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b1,8'hA0,8'hF0,8'h0B,4'b0110,1'b1,1'b0,16'd0};
      vecs[2] = '{1'b1,5'd3,5'd7,5'd11,8'h01,8'h02,8'h00,1'b0,4'b0000,1'b1,1'b0,1'b0,1'b0, 1'b1,5'd3,8'h7F, 1'b1,5'd3,8'h11, 1'b1,8'h7F,8'h02,8'h02,4'b0000,1'b1,1'b0,16'd0};
      vecs[3] = '{1'b1,5'd3,5'd7,5'd11,8'h01,8'h02,8'h00,1'b0,4'b0000,1'b1,1'b0,1'b0,1'b0, 1'b0,5'd3,8'h7F, 1'b1,5'd3,8'h11, 1'b1,8'h11,8'h02,8'h02,4'b0000,1'b1,1'b0,16'd0};
      vecs[4] = '{1'b1,5'd8,5'd9,5'd12,8'h22,8'h33,8'h44,1'b1,4'b0011,1'b1,1'b0,1'b0,1'b0, 1'b0,5'd9,8'h77, 1'b1,5'd9,8'h99, 1'b1,8'h22,8'h44,8'h99,4'b0011,1'b1,1'b0,16'd0};
      vecs[5] = '{1'b1,5'd0,5'd0,5'd13,8'hAB,8'hCD,8'h00,1'b0,4'b1100,1'b0,1'b0,1'b0,1'b0, 1'b1,5'd0,8'h55, 1'b1,5'd0,8'h66, 1'b1,8'h00,8'h00,8'h00,4'b1100,1'b0,1'b0,16'd0};
      vecs[6] = '{1'b0,5'd1,5'd2,5'd14,8'h10,8'h20,8'h00,1'b0,4'b0001,1'b1,1'b0,1'b1,1'b0, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,8'h10,8'h20,8'h20,4'b0001,1'b0,1'b0,16'd0};
      vecs[7] = '{1'b1,5'd1,5'd2,5'd15,8'h10,8'h20,8'h00,1'b0,4'b0001,1'b1,1'b0,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,8'h00,8'h00,8'h00,4'b0000,1'b0,1'b0,16'd1};
      vecs[8] = '{1'b1,5'd2,5'd5,5'd0,8'h40,8'h50,8'h04,1'b1,4'b0010,1'b0,1'b0,1'b1,1'b0, 1'b1,5'd5,8'h5A, 1'b0,5'd0,8'h00, 1'b1,8'h40,8'h04,8'h5A,4'b0010,1'b0,1'b1,16'd1};
      vecs[9] = '{1'b0,5'd1,5'd2,5'd3,8'h10,8'h20,8'h00,1'b0,4'b0010,1'b1,1'b0,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,8'h00,8'h00,8'h00,4'b0000,1'b0,1'b0,16'd1};

      // Power-on reset
      rst_n = 1'b0;
      drive('0);
      #12;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_bubble_count", bubble_count, 0);
      chk("rst_stall", stall_if_id, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ex_valid", i), ex_valid, vecs[i].e_vld);
         chk($sformatf("v%0d_data1", i), data1, vecs[i].e_d1);
         chk($sformatf("v%0d_data2", i), data2, vecs[i].e_d2);
         chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].e_st);
         chk($sformatf("v%0d_ctrl", i), ex_alu_control, vecs[i].e_ctrl);
         chk($sformatf("v%0d_reg_write", i), ex_reg_write, vecs[i].e_rw);
         chk($sformatf("v%0d_mem_write", i), ex_mem_write, vecs[i].e_mw);
         chk($sformatf("v%0d_bubble_count", i), bubble_count, vecs[i].e_bc);
      end

      // Load-use: one-cycle stall, then MEM/WB forwarding of the load result
      @(negedge clk);
      drive(load_vec());
      @(posedge clk); #1;
      chk("lu_ex_mem_read", ex_mem_read, 1);
      chk("lu_ex_rd", ex_rd_addr, 5);
      @(negedge clk);
      drive(dep_vec());
      #1;
      chk("lu_stall", stall_if_id, 1);
      @(posedge clk); #1;
      chk("lu_bubble_valid", ex_valid, 0);
      chk("lu_bubble_count", bubble_count, 2);
      chk("lu_stall_cleared", stall_if_id, 0);
      @(negedge clk);
      cur = dep_vec(); cur.ww = 1'b1; cur.wrd = 5'd5; cur.wdat = 8'h3C;
      drive(cur);
      @(posedge clk); #1;
      chk("lu_exec_valid", ex_valid, 1);
      chk("lu_exec_data1", data1, 8'h01);
      chk("lu_exec_data2", data2, 8'h3C);
      chk("lu_exec_rd", ex_rd_addr, 7);
      chk("lu_exec_bubble_count", bubble_count, 2);

      // Flush together with a load-use hazard: single bubble, no stall
      @(negedge clk);
      drive(load_vec());
      @(posedge clk);
      @(negedge clk);
      cur = dep_vec(); cur.flush = 1'b1;
      drive(cur);
      #1;
      chk("fl_stall", stall_if_id, 0);
      @(posedge clk); #1;
      chk("fl_ex_valid", ex_valid, 0);
      chk("fl_bubble_count", bubble_count, 3);

      // Mid-stream asynchronous reset
      @(negedge clk);
      drive(load_vec());
      @(posedge clk); #1;
      chk("mr_pre_valid", ex_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_ex_valid", ex_valid, 0);
      chk("mr_mem_read", ex_mem_read, 0);
      chk("mr_rd", ex_rd_addr, 0);
      chk("mr_data2", data2, 0);
      chk("mr_ctrl", ex_alu_control, 0);
      chk("mr_bubble_count", bubble_count, 0);
      @(negedge clk);
      drive('0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mr_rel_bubble_count", bubble_count, 0);
      chk("mr_rel_stall", stall_if_id, 0);
      chk("mr_rel_valid", ex_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
